// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared types and constants for the load/store unit:
//                FSM state encoding, funct3 access-width codes, error-cause
//                codes and the input legality helpers used in IDLE.
//  Revision    : 1.0  initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_FUNCT3   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    // Stores only have signed-width encodings; loads add the unsigned forms.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        if (we) begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end else begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

    // Width is carried in funct3[1:0] for every legal encoding.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        case (f3[1:0])
            2'b01:   bad = off[0];
            2'b10:   bad = (off != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Combinational lane logic. Always produces the byte-enable
//                pattern for (funct3, offset). With LOAD_PATH=0, o_data is
//                the lane-replicated store word; with LOAD_PATH=1, o_data is
//                the selected byte/halfword of i_data, sign- or zero-extended.
//  Ports       : i_funct3 [2:0]  access width/sign
//                i_offset [1:0]  byte offset within the word
//                i_data   [31:0] store data (store path) or read word (load)
//                o_be     [3:0]  byte enables
//                o_data   [31:0] replicated store data / extended load data
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
#(
    parameter bit LOAD_PATH = 1'b0
) (
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_data
);

    always_comb begin
        o_be = 4'b0000;
        case (i_funct3)
            F3_B, F3_BU: o_be = 4'b0001 << i_offset;
            F3_H, F3_HU: o_be = i_offset[1] ? 4'b1100 : 4'b0011;
            F3_W:        o_be = 4'b1111;
            default:     o_be = 4'b0000;
        endcase
    end

    generate
        if (LOAD_PATH) begin : g_load
            logic [7:0]  w_byte;
            logic [15:0] w_half;

            always_comb begin
                w_byte = i_data[{i_offset, 3'b000} +: 8];
                w_half = i_offset[1] ? i_data[31:16] : i_data[15:0];
                o_data = 32'h0;
                case (i_funct3)
                    F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
                    F3_BU:   o_data = {24'h0, w_byte};
                    F3_H:    o_data = {{16{w_half[15]}}, w_half};
                    F3_HU:   o_data = {16'h0, w_half};
                    F3_W:    o_data = i_data;
                    default: o_data = 32'h0;
                endcase
            end
        end else begin : g_store
            always_comb begin
                o_data = 32'h0;
                case (i_funct3)
                    F3_B, F3_BU: o_data = {4{i_data[7:0]}};
                    F3_H, F3_HU: o_data = {2{i_data[15:0]}};
                    F3_W:        o_data = i_data;
                    default:     o_data = 32'h0;
                endcase
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
//  Module      : lsu
//  Description : Load/store unit. Checks the access in IDLE, then holds a
//                request to data memory until ack or timeout, returning
//                extended load data with a one-cycle o_done pulse or a
//                one-cycle o_err pulse with cause.
//  Ports       : i_clk, i_rst_n          clock, async active-low reset
//                i_valid, i_lsu_wren     access request, 1 = store
//                i_funct3, i_addr        width/sign, effective address
//                i_st_data               store data (rs2)
//                o_stall                 hold PC/instruction
//                o_done, o_ld_data       completion pulse, load result
//                o_err, o_err_cause      fault pulse, cause code
//                o_mem_*                 memory request channel
//                i_mem_ack, i_mem_rdata  memory response
//  Revision    : 1.0  initial release
// ============================================================================
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic        i_lsu_wren,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_st_data,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_ld_data,
    output logic        o_err,
    output logic [1:0]  o_err_cause,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT_CYC - 1);

    lsu_state_t  r_state;
    lsu_state_t  w_next;
    logic [31:0] r_addr;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [15:0] r_cnt;
    logic [1:0]  r_cause;

    logic [1:0]  w_fault;
    logic        w_timeout;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_wdata;
    logic [3:0]  w_ld_be;
    logic [31:0] w_ld_data;
    logic [31:0] w_lane_mask;

    lsu_align #(.LOAD_PATH(1'b0)) u_align_st (
        .i_funct3 (i_funct3),
        .i_offset (i_addr[1:0]),
        .i_data   (i_st_data),
        .o_be     (w_st_be),
        .o_data   (w_st_wdata)
    );

    lsu_align #(.LOAD_PATH(1'b1)) u_align_ld (
        .i_funct3 (r_f3),
        .i_offset (r_addr[1:0]),
        .i_data   (r_rdata),
        .o_be     (w_ld_be),
        .o_data   (w_ld_data)
    );

    // Only the lanes the access touches are kept from the read word.
    assign w_lane_mask = {{8{w_ld_be[3]}}, {8{w_ld_be[2]}},
                          {8{w_ld_be[1]}}, {8{w_ld_be[0]}}};

    // funct3 legality outranks alignment.
    always_comb begin
        w_fault = ERR_NONE;
        if (!f3_legal(i_lsu_wren, i_funct3)) begin
            w_fault = ERR_FUNCT3;
        end else if (is_misaligned(i_funct3, i_addr[1:0])) begin
            w_fault = ERR_MISALIGN;
        end
    end

    assign w_timeout = (r_cnt == c_TO_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_addr  <= 32'h0;
            r_we    <= 1'b0;
            r_f3    <= 3'b000;
            r_be    <= 4'b0000;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
            r_cnt   <= 16'h0;
            r_cause <= ERR_NONE;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        if (w_fault != ERR_NONE) begin
                            r_cause <= w_fault;
                        end else begin
                            r_addr  <= i_addr;
                            r_we    <= i_lsu_wren;
                            r_f3    <= i_funct3;
                            r_be    <= w_st_be;
                            r_wdata <= w_st_wdata;
                            r_cnt   <= 16'h0;
                        end
                    end
                end
                WAIT: begin
                    // Ack wins over a simultaneous timeout.
                    if (i_mem_ack) begin
                        r_rdata <= i_mem_rdata & w_lane_mask;
                    end else if (w_timeout) begin
                        r_cause <= ERR_TIMEOUT;
                    end else begin
                        r_cnt <= r_cnt + 16'h1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next      = r_state;
        o_stall     = 1'b0;
        o_done      = 1'b0;
        o_ld_data   = 32'h0;
        o_err       = 1'b0;
        o_err_cause = ERR_NONE;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = 32'h0;
        o_mem_be    = 4'b0000;
        o_mem_wdata = 32'h0;
        case (r_state)
            IDLE: begin
                // Gated by reset so every output is low while reset is held.
                o_stall = i_valid & i_rst_n;
                if (i_valid) begin
                    w_next = (w_fault != ERR_NONE) ? ERR : WAIT;
                end
            end
            WAIT: begin
                o_stall     = 1'b1;
                o_mem_req   = 1'b1;
                o_mem_we    = r_we;
                o_mem_addr  = {r_addr[31:2], 2'b00};
                o_mem_be    = r_be;
                o_mem_wdata = r_wdata;
                if (i_mem_ack) begin
                    w_next = RESP;
                end else if (w_timeout) begin
                    w_next = ERR;
                end
            end
            RESP: begin
                o_done    = 1'b1;
                o_ld_data = r_we ? 32'h0 : w_ld_data;
                w_next    = IDLE;
            end
            ERR: begin
                o_err       = 1'b1;
                o_err_cause = r_cause;
                w_next      = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu
//  Description : Self-checking bench for lsu: directed accesses followed by
//                randomized loads/stores compared against a width/offset
//                arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lsu;

    localparam int TO = 4;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        i_lsu_wren;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_st_data;
    logic        o_stall;
    logic        o_done;
    logic [31:0] o_ld_data;
    logic        o_err;
    logic [1:0]  o_err_cause;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    lsu #(.TIMEOUT_CYC(TO)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .i_lsu_wren  (i_lsu_wren),
        .i_funct3    (i_funct3),
        .i_addr      (i_addr),
        .i_st_data   (i_st_data),
        .o_stall     (o_stall),
        .o_done      (o_done),
        .o_ld_data   (o_ld_data),
        .o_err       (o_err),
        .o_err_cause (o_err_cause),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_be    (o_mem_be),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic int model_cause(input bit we, input logic [2:0] f3, input logic [31:0] a);
        int f = int'(f3);
        bit legal = we ? (f <= 2) : (f <= 2 || f == 4 || f == 5);
        int sz;
        if (!legal) return 2;
        sz = acc_size(f3);
        if ((a % sz) != 0) return 1;
        return 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
        int sz = acc_size(f3);
        int off = int'(a % 4);
        int v = ((1 << sz) - 1) << off;
        return 4'(v);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] st);
        int sz = acc_size(f3);
        if (sz == 1) return (st & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (st & 32'hFFFF) * 32'h0001_0001;
        return st;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] sh = rd >> (8 * (a % 4));
        case (f3)
            3'd0:    return ((sh & 32'hFF) ^ 32'h80) - 32'h80;
            3'd4:    return sh & 32'hFF;
            3'd1:    return ((sh & 32'hFFFF) ^ 32'h8000) - 32'h8000;
            3'd5:    return sh & 32'hFFFF;
            default: return rd;
        endcase
    endfunction

    // ---------------- one access ----------------
    // ack_at: WAIT cycle (1-based) in which ack is driven; 0 or > TO = never.
    // late_ack: drive a stray ack in the accept cycle (must be ignored).
    task automatic run_access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] st, input logic [31:0] rd,
                              input int ack_at, input bit late_ack);
        int  cause = model_cause(we, f3, a);
        bit  acked = 0;
        @(posedge i_clk); #1;
        i_valid    = 1'b1;
        i_lsu_wren = we;
        i_funct3   = f3;
        i_addr     = a;
        i_st_data  = st;
        i_mem_ack  = late_ack;
        i_mem_rdata = $urandom;
        #1;
        chk("stall_accept", 32'(o_stall), 32'd1);
        chk("req_accept", 32'(o_mem_req), 32'd0);
        @(posedge i_clk); #1;
        i_mem_ack = 1'b0;
        i_valid   = 1'($urandom);
        i_funct3  = 3'($urandom);
        i_addr    = $urandom;
        i_st_data = $urandom;
        if (cause != 0) begin
            chk("err_pulse", 32'(o_err), 32'd1);
            chk("err_cause", 32'(o_err_cause), 32'(cause));
            chk("err_req", 32'(o_mem_req), 32'd0);
            chk("err_stall", 32'(o_stall), 32'd0);
            chk("err_done", 32'(o_done), 32'd0);
            i_valid = 1'b0;
            return;
        end
        for (int w = 1; w <= TO; w++) begin
            chk("wait_req", 32'(o_mem_req), 32'd1);
            chk("wait_stall", 32'(o_stall), 32'd1);
            chk("wait_we", 32'(o_mem_we), 32'(we));
            chk("wait_addr", o_mem_addr, a & ~32'h3);
            chk("wait_be", 32'(o_mem_be), 32'(exp_be(f3, a)));
            if (we) chk("wait_wdata", o_mem_wdata, exp_wdata(f3, st));
            chk("wait_done", 32'(o_done), 32'd0);
            if (w == ack_at) begin
                i_mem_ack   = 1'b1;
                i_mem_rdata = rd;
                acked = 1;
            end else begin
                i_mem_ack   = 1'b0;
                i_mem_rdata = $urandom;
            end
            i_valid  = 1'($urandom);
            i_funct3 = 3'($urandom);
            i_addr   = $urandom;
            @(posedge i_clk); #1;
            i_mem_ack   = 1'b0;
            i_mem_rdata = $urandom;
            if (acked) break;
        end
        if (acked) begin
            chk("resp_done", 32'(o_done), 32'd1);
            chk("resp_ld_data", o_ld_data, we ? 32'h0 : exp_load(f3, a, rd));
            chk("resp_stall", 32'(o_stall), 32'd0);
            chk("resp_req", 32'(o_mem_req), 32'd0);
            chk("resp_err", 32'(o_err), 32'd0);
        end else begin
            chk("to_err", 32'(o_err), 32'd1);
            chk("to_cause", 32'(o_err_cause), 32'd3);
            chk("to_req", 32'(o_mem_req), 32'd0);
            chk("to_done", 32'(o_done), 32'd0);
            chk("to_stall", 32'(o_stall), 32'd0);
        end
        i_valid = 1'b0;
    endtask

    initial begin
        i_rst_n     = 1'b0;
        i_valid     = 1'b0;
        i_lsu_wren  = 1'b0;
        i_funct3    = 3'b000;
        i_addr      = 32'h0;
        i_st_data   = 32'h0;
        i_mem_ack   = 1'b0;
        i_mem_rdata = 32'h0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_stall", 32'(o_stall), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_req", 32'(o_mem_req), 32'd0);
        chk("rst_ld_data", o_ld_data, 32'h0);
        i_rst_n = 1'b1;

        // Directed cases
        run_access(1'b0, 3'd2, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 3, 1'b0); // LW
        run_access(1'b0, 3'd0, 32'h0000_0013, 32'h0, 32'h8012_3456, 1, 1'b0); // LB
        run_access(1'b0, 3'd4, 32'h0000_0013, 32'h0, 32'h8012_3456, 2, 1'b0); // LBU
        run_access(1'b0, 3'd1, 32'h0000_0012, 32'h0, 32'h8001_5555, 1, 1'b0); // LH
        run_access(1'b1, 3'd0, 32'h0000_0021, 32'h1234_56AB, 32'h0, 2, 1'b0); // SB
        run_access(1'b1, 3'd1, 32'h0000_0022, 32'h0000_CAFE, 32'h0, 1, 1'b0); // SH
        run_access(1'b0, 3'd2, 32'h0000_0002, 32'h0, 32'h0, 1, 1'b0);         // misaligned
        run_access(1'b0, 3'd3, 32'h0000_0040, 32'h0, 32'h0, 1, 1'b0);         // bad load f3
        run_access(1'b1, 3'd7, 32'h0000_0003, 32'h0, 32'h0, 1, 1'b0);         // bad f3 + misaligned
        run_access(1'b0, 3'd2, 32'h0000_0100, 32'h0, 32'h0, 0, 1'b0);         // timeout
        run_access(1'b0, 3'd2, 32'h0000_0104, 32'h0, 32'h1357_9BDF, 2, 1'b1); // right after timeout
        run_access(1'b0, 3'd5, 32'h0000_0202, 32'h0, 32'hFEDC_BA98, TO, 1'b0); // ack on last cycle

        // Reset mid-WAIT
        @(posedge i_clk); #1;
        i_valid = 1'b1; i_lsu_wren = 1'b0; i_funct3 = 3'd2; i_addr = 32'h0000_0300;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        chk("pre_rst_req", 32'(o_mem_req), 32'd1);
        @(posedge i_clk); #3;
        i_rst_n = 1'b0;
        #1;
        chk("midrst_req", 32'(o_mem_req), 32'd0);
        chk("midrst_stall", 32'(o_stall), 32'd0);
        chk("midrst_done", 32'(o_done), 32'd0);
        chk("midrst_addr", o_mem_addr, 32'h0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        chk("postrst_stall", 32'(o_stall), 32'd0);
        run_access(1'b1, 3'd2, 32'h0000_0400, 32'hA5A5_5A5A, 32'h0, 1, 1'b0); // SW

        // Randomized accesses
        for (int k = 0; k < 60; k++) begin
            bit          we  = 1'($urandom);
            logic [2:0]  f3  = 3'($urandom_range(0, 7));
            logic [31:0] a   = $urandom;
            int          ack = $urandom_range(1, TO + 1);
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(acc_size(f3)) - 32'd1);
            run_access(we, f3, a, $urandom, $urandom, ack, 1'($urandom));
        end

        repeat (2) @(posedge i_clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
